// File: rtl/lcd_pkg.sv
// Shared types and HD44780-style command bytes for the LCD sequencer.
// Used by lcd_byte_writer and lcd_sequencer.
package lcd_pkg;

    typedef enum logic [2:0] {
        ST_PWR,
        ST_INIT,
        ST_IDLE,
        ST_CHAR,
        ST_ADDR,
        ST_CLEAR
    } lcd_state_t;

    typedef enum logic [1:0] {
        WR_IDLE,
        WR_SETUP,
        WR_EN,
        WR_WAIT
    } wr_state_t;

    localparam logic [7:0] CMD_FUNC_SET = 8'h38;
    localparam logic [7:0] CMD_DISP_ON  = 8'h0C;
    localparam logic [7:0] CMD_CLEAR    = 8'h01;
    localparam logic [7:0] CMD_ENTRY    = 8'h06;
    localparam logic [7:0] CMD_LINE1    = 8'h80;
    localparam logic [7:0] CMD_LINE2    = 8'hC0;

    localparam logic [1:0] INIT_LAST = 2'd3;

    // Power-on command list, in issue order.
    function automatic logic [7:0] init_cmd(input logic [1:0] idx);
        logic [7:0] w_cmd;
        unique case (idx)
            2'd0:    w_cmd = CMD_FUNC_SET;
            2'd1:    w_cmd = CMD_DISP_ON;
            2'd2:    w_cmd = CMD_CLEAR;
            default: w_cmd = CMD_ENTRY;
        endcase
        return w_cmd;
    endfunction

endpackage

// File: rtl/lcd_byte_writer.sv
// One LCD bus write: setup cycle, EN pulse, then post-write idle.
// Accepts i_start only while not busy; o_done flags the final wait cycle.
module lcd_byte_writer
    import lcd_pkg::*;
#(
    parameter int CLK_WAIT = 4,
    parameter int CMD_WAIT = 8,
    parameter int CLR_WAIT = 16
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_start,
    input  logic [7:0] i_data,
    input  logic       i_rs,
    output logic       o_busy,
    output logic       o_done,
    output logic [7:0] o_data,
    output logic       o_rs,
    output logic       o_en
);

    wr_state_t   r_state;
    logic [15:0] r_cnt;
    logic [7:0]  r_data;
    logic        r_rs;
    logic        r_en;
    logic        r_clr;
    logic [15:0] w_wait_last;
    logic [15:0] w_en_last;

    // A clear command needs the long settle time; everything else the short one.
    assign w_wait_last = r_clr ? 16'(CLR_WAIT - 1) : 16'(CMD_WAIT - 1);
    assign w_en_last   = 16'(CLK_WAIT - 1);

    assign o_busy = (r_state != WR_IDLE);
    assign o_done = (r_state == WR_WAIT) && (r_cnt == w_wait_last);
    assign o_data = r_data;
    assign o_rs   = r_rs;
    assign o_en   = r_en;

    // Write sequencer; DATA/RS are held from setup until the next start.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= WR_IDLE;
            r_cnt   <= '0;
            r_data  <= 8'h00;
            r_rs    <= 1'b0;
            r_en    <= 1'b0;
            r_clr   <= 1'b0;
        end else begin
            unique case (r_state)
                WR_IDLE: begin
                    if (i_start) begin
                        r_state <= WR_SETUP;
                        r_data  <= i_data;
                        r_rs    <= i_rs;
                        r_clr   <= !i_rs && (i_data == CMD_CLEAR);
                        r_en    <= 1'b0;
                        r_cnt   <= '0;
                    end
                end
                WR_SETUP: begin
                    r_state <= WR_EN;
                    r_en    <= 1'b1;
                    r_cnt   <= '0;
                end
                WR_EN: begin
                    if (r_cnt == w_en_last) begin
                        r_state <= WR_WAIT;
                        r_en    <= 1'b0;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                WR_WAIT: begin
                    if (o_done) begin
                        r_state <= WR_IDLE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                default: begin
                    r_state <= WR_IDLE;
                    r_en    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/lcd_sequencer.sv
// Character LCD front end: power-up wait, init commands, char/clear writes.
// Optional LCD_AUTO_WRAP_EN inserts line-address commands at pos 16 and 0.
module lcd_sequencer
    import lcd_pkg::*;
#(
    parameter int PWR_WAIT = 20,
    parameter int CLK_WAIT = 4,
    parameter int CMD_WAIT = 8,
    parameter int CLR_WAIT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] char_data,
    input  logic       char_valid,
    output logic       char_ready,
    input  logic       clear_req,
    output logic       init_done,
    output logic [7:0] LCD_DATA,
    output logic       LCD_EN,
    output logic       LCD_RS,
    output logic       LCD_RW,
    output logic       LCD_ON
);

    lcd_state_t  r_state;
    logic [15:0] r_pwr_cnt;
    logic [1:0]  r_idx;
    logic        r_init_done;
    logic [4:0]  r_pos;
    logic        r_clr_pend;
    logic        r_addr_pend;
    logic [7:0]  r_addr_cmd;

    logic        w_busy;
    logic        w_done;
    logic        w_start;
    logic [7:0]  w_byte;
    logic        w_rs;
    logic        w_in_idle;
    logic        w_pwr_go;
    logic        w_init_go;
    logic        w_clr_go;
    logic        w_addr_go;
    logic        w_char_go;

    assign w_in_idle = (r_state == ST_IDLE) && !w_busy;
    assign w_pwr_go  = (r_state == ST_PWR) &&
                       (r_pwr_cnt == 16'(PWR_WAIT - 1));
    assign w_init_go = (r_state == ST_INIT) && !w_busy;
    assign w_clr_go  = w_in_idle && (clear_req || r_clr_pend);
    assign w_addr_go = w_in_idle && !w_clr_go && r_addr_pend;

    // A clear arriving this cycle, or one still queued, blocks the char.
    assign char_ready = w_in_idle && r_init_done && !r_addr_pend &&
                        !r_clr_pend && !clear_req;
    assign w_char_go  = char_valid && char_ready;

    assign init_done = r_init_done;
    assign LCD_RW    = 1'b0;
    assign LCD_ON    = 1'b1;

    // Select the byte to launch; the go terms are mutually exclusive.
    always_comb begin
        w_start = 1'b0;
        w_byte  = 8'h00;
        w_rs    = 1'b0;
        unique case (1'b1)
            w_pwr_go: begin
                w_start = 1'b1;
                w_byte  = CMD_FUNC_SET;
            end
            w_init_go: begin
                w_start = 1'b1;
                w_byte  = init_cmd(r_idx);
            end
            w_clr_go: begin
                w_start = 1'b1;
                w_byte  = CMD_CLEAR;
            end
            w_addr_go: begin
                w_start = 1'b1;
                w_byte  = r_addr_cmd;
            end
            w_char_go: begin
                w_start = 1'b1;
                w_byte  = char_data;
                w_rs    = 1'b1;
            end
            default: begin
                w_start = 1'b0;
            end
        endcase
    end

    // Top-level state machine; the first init command launches on PWR exit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_PWR;
            r_pwr_cnt   <= '0;
            r_idx       <= 2'd0;
            r_init_done <= 1'b0;
            r_pos       <= 5'd0;
            r_clr_pend  <= 1'b0;
            r_addr_pend <= 1'b0;
            r_addr_cmd  <= CMD_LINE2;
        end else begin
            if (clear_req && (r_state != ST_IDLE)) begin
                r_clr_pend <= 1'b1;
            end
            unique case (r_state)
                ST_PWR: begin
                    if (w_pwr_go) begin
                        r_state   <= ST_INIT;
                        r_idx     <= 2'd0;
                        r_pwr_cnt <= '0;
                    end else begin
                        r_pwr_cnt <= r_pwr_cnt + 16'd1;
                    end
                end
                ST_INIT: begin
                    if (w_done) begin
                        if (r_idx == INIT_LAST) begin
                            r_init_done <= 1'b1;
                            r_state     <= ST_IDLE;
                        end else begin
                            r_idx <= r_idx + 2'd1;
                        end
                    end
                end
                ST_IDLE: begin
                    if (w_clr_go) begin
                        r_state     <= ST_CLEAR;
                        r_pos       <= 5'd0;
                        r_clr_pend  <= 1'b0;
                        r_addr_pend <= 1'b0;
                    end else if (w_addr_go) begin
                        r_state     <= ST_ADDR;
                        r_addr_pend <= 1'b0;
                    end else if (w_char_go) begin
                        r_state <= ST_CHAR;
                        r_pos   <= r_pos + 5'd1;
`ifdef LCD_AUTO_WRAP_EN
                        if (r_pos == 5'd15) begin
                            r_addr_pend <= 1'b1;
                            r_addr_cmd  <= CMD_LINE2;
                        end else if (r_pos == 5'd31) begin
                            r_addr_pend <= 1'b1;
                            r_addr_cmd  <= CMD_LINE1;
                        end
`else
                        r_addr_pend <= 1'b0;
`endif
                    end
                end
                ST_CHAR, ST_ADDR, ST_CLEAR: begin
                    if (w_done) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_PWR;
                end
            endcase
        end
    end

    lcd_byte_writer #(
        .CLK_WAIT (CLK_WAIT),
        .CMD_WAIT (CMD_WAIT),
        .CLR_WAIT (CLR_WAIT)
    ) u_writer (
        .i_clk   (clk),
        .i_rst_n (reset),
        .i_start (w_start),
        .i_data  (w_byte),
        .i_rs    (w_rs),
        .o_busy  (w_busy),
        .o_done  (w_done),
        .o_data  (LCD_DATA),
        .o_rs    (LCD_RS),
        .o_en    (LCD_EN)
    );

endmodule

// File: tb/tb_lcd_sequencer.sv
// Scoreboard bench for lcd_sequencer: expected bus writes are queued
// at stimulus time and matched against writes seen on the LCD pins.
module tb_lcd_sequencer;

    localparam int PWR_WAIT = 20;
    localparam int CLK_WAIT = 4;
    localparam int CMD_WAIT = 8;
    localparam int CLR_WAIT = 16;
    localparam int EXP_FIRST_EN = PWR_WAIT + 1;
    localparam int EXP_INIT_DONE = PWR_WAIT + 4 * (1 + CLK_WAIT) +
                                   3 * CMD_WAIT + CLR_WAIT + 3;
    localparam int EXP_CHAR_LAT = 1 + CLK_WAIT + CMD_WAIT;
    localparam int EXP_CLR_LAT = 1 + CLK_WAIT + CLR_WAIT;

    logic       clk;
    logic       reset;
    logic [7:0] char_data;
    logic       char_valid;
    logic       char_ready;
    logic       clear_req;
    logic       init_done;
    logic [7:0] LCD_DATA;
    logic       LCD_EN;
    logic       LCD_RS;
    logic       LCD_RW;
    logic       LCD_ON;

    lcd_sequencer #(
        .PWR_WAIT (PWR_WAIT),
        .CLK_WAIT (CLK_WAIT),
        .CMD_WAIT (CMD_WAIT),
        .CLR_WAIT (CLR_WAIT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .char_data  (char_data),
        .char_valid (char_valid),
        .char_ready (char_ready),
        .clear_req  (clear_req),
        .init_done  (init_done),
        .LCD_DATA   (LCD_DATA),
        .LCD_EN     (LCD_EN),
        .LCD_RS     (LCD_RS),
        .LCD_RW     (LCD_RW),
        .LCD_ON     (LCD_ON)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt++;

    typedef struct packed {
        logic       rs;
        logic [7:0] data;
    } wr_t;

    typedef struct packed {
        logic       rs;
        logic [7:0] data;
        logic [7:0] len;
        logic       stable;
    } obs_t;

    wr_t  exp_q[$];
    obs_t obs_q[$];
    int   n_checks = 0;
    int   n_fail = 0;

    logic       m_prev_en = 1'b0;
    logic [7:0] m_last_data = 8'h00;
    logic       m_last_rs = 1'b0;
    logic [7:0] m_data = 8'h00;
    logic       m_rs = 1'b0;
    int         m_len = 0;
    logic       m_stable = 1'b0;

    // Bus monitor: one record per EN pulse, with setup/hold stability.
    always @(negedge clk) begin
        if (!reset) begin
            m_prev_en = 1'b0;
            m_len = 0;
        end else begin
            if (LCD_EN && !m_prev_en) begin
                m_data = LCD_DATA;
                m_rs = LCD_RS;
                m_stable = (LCD_DATA == m_last_data) && (LCD_RS == m_last_rs);
                m_len = 1;
            end else if (LCD_EN) begin
                m_len++;
                if (LCD_DATA != m_data || LCD_RS != m_rs) m_stable = 1'b0;
            end else if (m_prev_en) begin
                obs_q.push_back(obs_t'({m_rs, m_data, 8'(m_len), m_stable}));
            end
            m_prev_en = LCD_EN;
            m_last_data = LCD_DATA;
            m_last_rs = LCD_RS;
        end
    end

    task automatic wait_ready(output int cycles, output logic ok);
        cycles = 0;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (char_ready) begin
                ok = 1'b1;
                break;
            end
            cycles++;
        end
    endtask

    task automatic send_char(input logic [7:0] c, output logic ok);
        int cyc;
        wait_ready(cyc, ok);
        if (!ok) return;
        char_data = c;
        char_valid = 1'b1;
        exp_q.push_back(wr_t'({1'b1, c}));
        @(posedge clk);
        #1;
        char_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        char_valid = 1'b0;
        char_data = 8'h00;
        clear_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({LCD_EN, LCD_RS, LCD_DATA} !== 10'h000) begin
            n_fail++;
            $display("FAIL reset_bus: en/rs/data=%b/%b/%h required 0/0/00",
                     LCD_EN, LCD_RS, LCD_DATA);
        end
        n_checks++;
        if ({char_ready, init_done} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_flags: ready/init_done=%b/%b required 0/0",
                     char_ready, init_done);
        end
        n_checks++;
        if ({LCD_RW, LCD_ON} !== 2'b01) begin
            n_fail++;
            $display("FAIL rw_on: rw/on=%b/%b required 0/1", LCD_RW, LCD_ON);
        end
    endtask

    task automatic test_init();
        int base;
        int rel;
        logic found;
        @(negedge clk);
        reset = 1'b1;
        base = edge_cnt;
        exp_q.push_back(wr_t'({1'b0, 8'h38}));
        exp_q.push_back(wr_t'({1'b0, 8'h0C}));
        exp_q.push_back(wr_t'({1'b0, 8'h01}));
        exp_q.push_back(wr_t'({1'b0, 8'h06}));
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            if (LCD_EN) begin
                found = 1'b1;
                break;
            end
        end
        rel = edge_cnt - base;
        n_checks++;
        if (!found || rel != EXP_FIRST_EN) begin
            n_fail++;
            $display("FAIL first_en: cycle %0d (seen=%b) required %0d",
                     rel, found, EXP_FIRST_EN);
        end
        n_checks++;
        if ({LCD_RS, LCD_DATA} !== 9'h038) begin
            n_fail++;
            $display("FAIL first_cmd: rs/data=%b/%h required 0/38",
                     LCD_RS, LCD_DATA);
        end
        found = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            #1;
            if (init_done) begin
                found = 1'b1;
                break;
            end
        end
        rel = edge_cnt - base;
        n_checks++;
        if (!found || rel != EXP_INIT_DONE) begin
            n_fail++;
            $display("FAIL init_done: cycle %0d (seen=%b) required %0d",
                     rel, found, EXP_INIT_DONE);
        end
        n_checks++;
        if (char_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL ready_after_init: %b required 1", char_ready);
        end
        n_checks++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL init_count: %0d writes required %0d",
                     obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            wr_t e;
            obs_t o;
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++;
            if ({o.rs, o.data, o.len, o.stable} !==
                {e.rs, e.data, 8'(CLK_WAIT), 1'b1}) begin
                n_fail++;
                $display("FAIL init_write: rs/data/len/stable=%b/%h/%0d/%b required %b/%h/%0d/1",
                         o.rs, o.data, o.len, o.stable, e.rs, e.data, CLK_WAIT);
            end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_char();
        int cyc;
        logic ok;
        send_char(8'h41, ok);
        wait_ready(cyc, ok);
        n_checks++;
        if (!ok || cyc != EXP_CHAR_LAT) begin
            n_fail++;
            $display("FAIL char_latency: %0d cycles (ok=%b) required %0d",
                     cyc, ok, EXP_CHAR_LAT);
        end
        n_checks++;
        if (dut.r_pos !== 5'd1) begin
            n_fail++;
            $display("FAIL char_pos: %0d required 1", dut.r_pos);
        end
        n_checks++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL char_count: %0d writes required %0d",
                     obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            wr_t e;
            obs_t o;
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++;
            if ({o.rs, o.data, o.len, o.stable} !==
                {e.rs, e.data, 8'(CLK_WAIT), 1'b1}) begin
                n_fail++;
                $display("FAIL char_write: rs/data/len/stable=%b/%h/%0d/%b required %b/%h/%0d/1",
                         o.rs, o.data, o.len, o.stable, e.rs, e.data, CLK_WAIT);
            end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_clear_collision();
        int cyc;
        logic ok;
        wait_ready(cyc, ok);
        char_data = 8'h42;
        char_valid = 1'b1;
        clear_req = 1'b1;
        exp_q.push_back(wr_t'({1'b0, 8'h01}));
        #1;
        n_checks++;
        if (char_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL collide_ready: %b required 0", char_ready);
        end
        @(posedge clk);
        #1;
        clear_req = 1'b0;
        char_valid = 1'b0;
        wait_ready(cyc, ok);
        n_checks++;
        if (!ok || cyc != EXP_CLR_LAT) begin
            n_fail++;
            $display("FAIL clear_latency: %0d cycles (ok=%b) required %0d",
                     cyc, ok, EXP_CLR_LAT);
        end
        n_checks++;
        if (dut.r_pos !== 5'd0) begin
            n_fail++;
            $display("FAIL clear_pos: %0d required 0", dut.r_pos);
        end
        n_checks++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL collide_count: %0d writes required %0d",
                     obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            wr_t e;
            obs_t o;
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++;
            if ({o.rs, o.data, o.len, o.stable} !==
                {e.rs, e.data, 8'(CLK_WAIT), 1'b1}) begin
                n_fail++;
                $display("FAIL collide_write: rs/data/len/stable=%b/%h/%0d/%b required %b/%h/%0d/1",
                         o.rs, o.data, o.len, o.stable, e.rs, e.data, CLK_WAIT);
            end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_clear_during_char();
        int cyc;
        logic ok;
        send_char(8'h43, ok);
        repeat (3) @(negedge clk);
        clear_req = 1'b1;
        exp_q.push_back(wr_t'({1'b0, 8'h01}));
        @(negedge clk);
        clear_req = 1'b0;
        wait_ready(cyc, ok);
        cyc = cyc + 4;
        n_checks++;
        if (!ok || cyc != EXP_CHAR_LAT + 1 + EXP_CLR_LAT) begin
            n_fail++;
            $display("FAIL pend_clear_latency: %0d cycles (ok=%b) required %0d",
                     cyc, ok, EXP_CHAR_LAT + 1 + EXP_CLR_LAT);
        end
        n_checks++;
        if (dut.r_pos !== 5'd0) begin
            n_fail++;
            $display("FAIL pend_clear_pos: %0d required 0", dut.r_pos);
        end
        n_checks++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL pend_count: %0d writes required %0d",
                     obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            wr_t e;
            obs_t o;
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++;
            if ({o.rs, o.data, o.len, o.stable} !==
                {e.rs, e.data, 8'(CLK_WAIT), 1'b1}) begin
                n_fail++;
                $display("FAIL pend_write: rs/data/len/stable=%b/%h/%0d/%b required %b/%h/%0d/1",
                         o.rs, o.data, o.len, o.stable, e.rs, e.data, CLK_WAIT);
            end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_stream_wrap();
        int cyc;
        logic ok;
        for (int i = 0; i < 33; i++) begin
            send_char(8'h61 + 8'(i % 26), ok);
            if (!ok) break;
`ifdef LCD_AUTO_WRAP_EN
            if (i == 15) exp_q.push_back(wr_t'({1'b0, 8'hC0}));
            if (i == 31) exp_q.push_back(wr_t'({1'b0, 8'h80}));
`endif
        end
        wait_ready(cyc, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL stream_timeout: ready=%b required 1", char_ready);
        end
        n_checks++;
        if (dut.r_pos !== 5'd1) begin
            n_fail++;
            $display("FAIL stream_pos: %0d required 1", dut.r_pos);
        end
        n_checks++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL stream_count: %0d writes required %0d",
                     obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            wr_t e;
            obs_t o;
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++;
            if ({o.rs, o.data, o.len, o.stable} !==
                {e.rs, e.data, 8'(CLK_WAIT), 1'b1}) begin
                n_fail++;
                $display("FAIL stream_write: rs/data/len/stable=%b/%h/%0d/%b required %b/%h/%0d/1",
                         o.rs, o.data, o.len, o.stable, e.rs, e.data, CLK_WAIT);
            end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_reset_midwrite();
        logic ok;
        logic found;
        send_char(8'h5A, ok);
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (LCD_EN) begin
                found = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        n_checks++;
        if (!found) begin
            n_fail++;
            $display("FAIL midwrite_en: EN never high, required 1");
        end
        #1;
        reset = 1'b0;
        #1;
        n_checks++;
        if ({LCD_EN, LCD_RS, LCD_DATA, char_ready, init_done} !== 12'h000) begin
            n_fail++;
            $display("FAIL midwrite_reset: en/rs/data/ready/done=%b/%b/%h/%b/%b required 0/0/00/0/0",
                     LCD_EN, LCD_RS, LCD_DATA, char_ready, init_done);
        end
        n_checks++;
        if ({dut.r_pos, dut.r_clr_pend} !== 6'd0) begin
            n_fail++;
            $display("FAIL midwrite_state: pos/pend=%0d/%b required 0/0",
                     dut.r_pos, dut.r_clr_pend);
        end
        exp_q.delete();
        obs_q.delete();
        repeat (2) @(posedge clk);
        test_init();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time exceeded, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_init();
        test_char();
        test_clear_collision();
        test_clear_during_char();
        test_stream_wrap();
        test_reset_midwrite();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
